axil_protocol_monitor: RTL

//  Synthesizable AXI4-Lite passive monitor combining master- and slave-side rule checks on one interface.

---
 rtl/axil_mon_pkg.sv | 33 +++
 rtl/axil_mon_counter.sv | 35 +++
 rtl/axil_protocol_monitor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mon_pkg.sv
// Shared constants for the AXI4-Lite protocol monitor.
// Error bit indices, response codes and the first-error encoder.
package axil_mon_pkg;

    localparam int ERR_W         = 12;
    localparam int ERR_AW_STABLE = 0;
    localparam int ERR_W_STABLE  = 1;
    localparam int ERR_AR_STABLE = 2;
    localparam int ERR_B_STABLE  = 3;
    localparam int ERR_R_STABLE  = 4;
    localparam int ERR_B_EARLY   = 5;
    localparam int ERR_R_EARLY   = 6;
    localparam int ERR_OVF       = 7;
    localparam int ERR_BRESP     = 8;
    localparam int ERR_RRESP     = 9;
    localparam int ERR_REQ_WAIT  = 10;
    localparam int ERR_RSP_DELAY = 11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [3:0] first_set(input logic [ERR_W-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axil_mon_counter.sv
// Saturating up/down outstanding-transaction counter.
// Flags an increment at max or a decrement at zero; the count holds.
module axil_mon_counter #(
    parameter int LGD = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_inc,
    input  logic           i_dec,
    output logic [LGD-1:0] o_count,
    output logic           o_ovf,
    output logic           o_unf
);

    logic [LGD-1:0] r_count;
    logic           w_max;
    logic           w_zero;

    assign w_max   = &r_count;
    assign w_zero  = (r_count == '0);
    assign o_ovf   = i_inc && !i_dec && w_max;
    assign o_unf   = i_dec && !i_inc && w_zero;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !w_max) begin
            r_count <= r_count + LGD'(1);
        end else if (i_dec && !i_inc && !w_zero) begin
            r_count <= r_count - LGD'(1);
        end
    end

endmodule

// File: rtl/axil_protocol_monitor.sv
// Passive AXI4-Lite protocol monitor with sticky violation capture.
// Define AXIL_MON_TIMEOUT_EN to build the request-wait/response-delay checks.
module axil_protocol_monitor
    import axil_mon_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int F_LGDEPTH        = 4,
    parameter bit F_OPT_BRESP      = 1'b1,
    parameter bit F_OPT_RRESP      = 1'b1,
    parameter int F_AXI_MAXWAIT    = 16,
    parameter int F_AXI_MAXDELAY   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_axi_reset_n,
    input  logic                          i_axi_awvalid,
    input  logic                          i_axi_awready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
    input  logic [2:0]                    i_axi_awprot,
    input  logic                          i_axi_wvalid,
    input  logic                          i_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
    input  logic                          i_axi_bvalid,
    input  logic                          i_axi_bready,
    input  logic [1:0]                    i_axi_bresp,
    input  logic                          i_axi_arvalid,
    input  logic                          i_axi_arready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
    input  logic [2:0]                    i_axi_arprot,
    input  logic                          i_axi_rvalid,
    input  logic                          i_axi_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
    input  logic [1:0]                    i_axi_rresp,
    input  logic                          i_clear,
    output logic [F_LGDEPTH-1:0]          o_rd_outstanding,
    output logic [F_LGDEPTH-1:0]          o_awr_outstanding,
    output logic [F_LGDEPTH-1:0]          o_wr_outstanding,
    output logic [ERR_W-1:0]              o_err,
    output logic                          o_err_any,
    output logic [3:0]                    o_first_err,
    output logic                          o_first_err_vld
);

    localparam int AWP = C_AXI_ADDR_WIDTH + 3;
    localparam int WP  = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
    localparam int RP  = C_AXI_DATA_WIDTH + 2;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_rd_ovf, w_rd_unf, w_awr_ovf, w_awr_unf, w_wr_ovf, w_wr_unf;
    logic w_to_wait, w_to_delay;
    logic [AWP-1:0] w_aw_pl, w_ar_pl;
    logic [WP-1:0]  w_w_pl;
    logic [RP-1:0]  w_r_pl;
    logic [ERR_W-1:0] w_det;

    logic           r_armed;
    logic           r_aw_stall, r_w_stall, r_ar_stall, r_b_stall, r_r_stall;
    logic [AWP-1:0] r_aw_pl, r_ar_pl;
    logic [WP-1:0]  r_w_pl;
    logic [1:0]     r_b_pl;
    logic [RP-1:0]  r_r_pl;
    logic [ERR_W-1:0] r_err;
    logic           r_err_any;
    logic [3:0]     r_first_err;
    logic           r_first_vld;

    assign w_aw_hs = i_axi_awvalid && i_axi_awready;
    assign w_w_hs  = i_axi_wvalid && i_axi_wready;
    assign w_b_hs  = i_axi_bvalid && i_axi_bready;
    assign w_ar_hs = i_axi_arvalid && i_axi_arready;
    assign w_r_hs  = i_axi_rvalid && i_axi_rready;

    assign w_aw_pl = {i_axi_awaddr, i_axi_awprot};
    assign w_ar_pl = {i_axi_araddr, i_axi_arprot};
    assign w_w_pl  = {i_axi_wdata, i_axi_wstrb};
    assign w_r_pl  = {i_axi_rdata, i_axi_rresp};

    axil_mon_counter #(.LGD(F_LGDEPTH)) u_rd_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_axi_reset_n),
        .i_inc   (w_ar_hs),
        .i_dec   (w_r_hs),
        .o_count (o_rd_outstanding),
        .o_ovf   (w_rd_ovf),
        .o_unf   (w_rd_unf)
    );

    axil_mon_counter #(.LGD(F_LGDEPTH)) u_awr_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_axi_reset_n),
        .i_inc   (w_aw_hs),
        .i_dec   (w_b_hs),
        .o_count (o_awr_outstanding),
        .o_ovf   (w_awr_ovf),
        .o_unf   (w_awr_unf)
    );

    axil_mon_counter #(.LGD(F_LGDEPTH)) u_wr_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_axi_reset_n),
        .i_inc   (w_w_hs),
        .i_dec   (w_b_hs),
        .o_count (o_wr_outstanding),
        .o_ovf   (w_wr_ovf),
        .o_unf   (w_wr_unf)
    );

    // Payload snapshots taken whenever a channel is stalled
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_armed    <= 1'b0;
            r_aw_stall <= 1'b0;
            r_w_stall  <= 1'b0;
            r_ar_stall <= 1'b0;
            r_b_stall  <= 1'b0;
            r_r_stall  <= 1'b0;
            r_aw_pl    <= '0;
            r_w_pl     <= '0;
            r_ar_pl    <= '0;
            r_b_pl     <= '0;
            r_r_pl     <= '0;
        end else begin
            r_armed    <= 1'b1;
            r_aw_stall <= i_axi_awvalid && !i_axi_awready;
            r_w_stall  <= i_axi_wvalid && !i_axi_wready;
            r_ar_stall <= i_axi_arvalid && !i_axi_arready;
            r_b_stall  <= i_axi_bvalid && !i_axi_bready;
            r_r_stall  <= i_axi_rvalid && !i_axi_rready;
            if (i_axi_awvalid && !i_axi_awready) r_aw_pl <= w_aw_pl;
            if (i_axi_wvalid && !i_axi_wready)   r_w_pl  <= w_w_pl;
            if (i_axi_arvalid && !i_axi_arready) r_ar_pl <= w_ar_pl;
            if (i_axi_bvalid && !i_axi_bready)   r_b_pl  <= i_axi_bresp;
            if (i_axi_rvalid && !i_axi_rready)   r_r_pl  <= w_r_pl;
        end
    end

`ifdef AXIL_MON_TIMEOUT_EN
    localparam int WLIM = (F_AXI_MAXWAIT > 0) ? F_AXI_MAXWAIT - 1 : 0;
    localparam int DLIM = (F_AXI_MAXDELAY > 0) ? F_AXI_MAXDELAY - 1 : 0;
    localparam int WWD  = (WLIM > 1) ? $clog2(WLIM + 1) : 1;
    localparam int DWD  = (DLIM > 1) ? $clog2(DLIM + 1) : 1;

    logic           w_aw_wait, w_w_wait, w_ar_wait, w_rsp_wait;
    logic [WWD-1:0] r_aw_wcnt, r_w_wcnt, r_ar_wcnt;
    logic [DWD-1:0] r_rsp_cnt;

    assign w_aw_wait  = i_axi_awvalid && !i_axi_awready;
    assign w_w_wait   = i_axi_wvalid && !i_axi_wready;
    assign w_ar_wait  = i_axi_arvalid && !i_axi_arready;
    assign w_rsp_wait = ((o_rd_outstanding != '0) ||
                         (o_awr_outstanding != '0) ||
                         (o_wr_outstanding != '0)) &&
                        !i_axi_bvalid && !i_axi_rvalid;

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_aw_wcnt <= '0;
            r_w_wcnt  <= '0;
            r_ar_wcnt <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (!w_aw_wait) r_aw_wcnt <= '0;
            else if (r_aw_wcnt != WWD'(WLIM)) r_aw_wcnt <= r_aw_wcnt + WWD'(1);
            if (!w_w_wait) r_w_wcnt <= '0;
            else if (r_w_wcnt != WWD'(WLIM)) r_w_wcnt <= r_w_wcnt + WWD'(1);
            if (!w_ar_wait) r_ar_wcnt <= '0;
            else if (r_ar_wcnt != WWD'(WLIM)) r_ar_wcnt <= r_ar_wcnt + WWD'(1);
            if (!w_rsp_wait) r_rsp_cnt <= '0;
            else if (r_rsp_cnt != DWD'(DLIM)) r_rsp_cnt <= r_rsp_cnt + DWD'(1);
        end
    end

    // Fires on the Nth consecutive cycle and keeps firing while it persists
    assign w_to_wait = (F_AXI_MAXWAIT != 0) &&
                       ((w_aw_wait && r_aw_wcnt == WWD'(WLIM)) ||
                        (w_w_wait && r_w_wcnt == WWD'(WLIM)) ||
                        (w_ar_wait && r_ar_wcnt == WWD'(WLIM)));
    assign w_to_delay = (F_AXI_MAXDELAY != 0) && w_rsp_wait &&
                        (r_rsp_cnt == DWD'(DLIM));
`else
    assign w_to_wait  = 1'b0;
    assign w_to_delay = 1'b0;
`endif

    always_comb begin
        w_det = '0;
        w_det[ERR_AW_STABLE] = r_aw_stall &&
                               (!i_axi_awvalid || w_aw_pl != r_aw_pl);
        w_det[ERR_W_STABLE]  = r_w_stall &&
                               (!i_axi_wvalid || w_w_pl != r_w_pl);
        w_det[ERR_AR_STABLE] = r_ar_stall &&
                               (!i_axi_arvalid || w_ar_pl != r_ar_pl);
        w_det[ERR_B_STABLE]  = r_b_stall &&
                               (!i_axi_bvalid || i_axi_bresp != r_b_pl);
        w_det[ERR_R_STABLE]  = r_r_stall &&
                               (!i_axi_rvalid || w_r_pl != r_r_pl);
        w_det[ERR_B_EARLY]   = (i_axi_bvalid &&
                                (o_awr_outstanding == '0 ||
                                 o_wr_outstanding == '0)) ||
                               w_awr_unf || w_wr_unf;
        w_det[ERR_R_EARLY]   = (i_axi_rvalid && o_rd_outstanding == '0) ||
                               w_rd_unf;
        w_det[ERR_OVF]       = w_rd_ovf || w_awr_ovf || w_wr_ovf;
        w_det[ERR_BRESP]     = !F_OPT_BRESP && w_b_hs &&
                               (i_axi_bresp != RESP_OKAY);
        w_det[ERR_RRESP]     = !F_OPT_RRESP && w_r_hs &&
                               (i_axi_rresp != RESP_OKAY);
        w_det[ERR_REQ_WAIT]  = w_to_wait;
        w_det[ERR_RSP_DELAY] = w_to_delay;
        if (!r_armed) w_det = '0;
    end

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_err       <= '0;
            r_err_any   <= 1'b0;
            r_first_err <= 4'd0;
            r_first_vld <= 1'b0;
        end else if (i_clear) begin
            r_err       <= '0;
            r_err_any   <= 1'b0;
            r_first_err <= 4'd0;
            r_first_vld <= 1'b0;
        end else begin
            r_err     <= r_err | w_det;
            r_err_any <= |(r_err | w_det);
            if (!r_first_vld && (|w_det)) begin
                r_first_err <= first_set(w_det);
                r_first_vld <= 1'b1;
            end
        end
    end

    assign o_err           = r_err;
    assign o_err_any       = r_err_any;
    assign o_first_err     = r_first_err;
    assign o_first_err_vld = r_first_vld;

endmodule
